// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with selectable fixed-priority (highest index
// wins) or round-robin arbitration. Every output comes from a flop, so the
// result of a sample taken at one rising edge is visible after the next edge.
module prio_encoder_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         mode,
  input  logic [N-1:0] req,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_grant,
  output logic         out_any
);

  // Round-robin start pointer; always kept in 0..N-1, even for non-power-of-two N.
  logic [W-1:0] ptr;

  logic         any_req;
  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_idx;
  logic         rr_found;
  logic [W-1:0] ptr_next;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_grant;

  // Adds an offset to an index modulo N. The base is always below N and the
  // offset never exceeds N, so a single conditional subtract suffices.
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    return W'(sum);
  endfunction

  assign any_req = |req;

  // Fixed priority: scan upward so the highest set bit is the last one written.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fix_idx = W'(i);
    end
  end

  // Round-robin: visit ptr, ptr+1, ..., N-1, 0, ..., ptr-1; first set bit wins.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!rr_found && req[wrap_add(ptr, i)]) begin
        rr_found = 1'b1;
        rr_idx   = wrap_add(ptr, i);
      end
    end
  end

  // Pointer moves to the slot just past the winner, wrapping N-1 back to 0.
  assign ptr_next = wrap_add(rr_idx, 1);

  // Select the winner for the active mode; an empty request encodes as zero.
  always_comb begin
    win_idx   = '0;
    win_grant = '0;
    if (any_req) begin
      win_idx   = mode ? rr_idx : fix_idx;
      win_grant = N'(1) << win_idx;
    end
  end

  // Output and pointer registers; reset wins over any coincident sample.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_grant <= '0;
      out_any   <= 1'b0;
      ptr       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_idx   <= win_idx;
        out_grant <= win_grant;
        out_any   <= any_req;
        // In fixed mode the pointer is left alone so round-robin resumes later.
        if (mode && any_req) ptr <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Self-checking bench for prio_encoder_rr: a vector table for an N=8 instance
// plus short hand-written sequences for N=4 and N=5 instances. Expected
// results are queued as stimulus is applied and compared after the edge.
module tb_prio_encoder_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance
  logic       rst8, iv8, mode8;
  logic [7:0] req8;
  logic       ov8, any8;
  logic [2:0] idx8;
  logic [7:0] gnt8;

  // N=4 instance
  logic       rst4, iv4, mode4;
  logic [3:0] req4;
  logic       ov4, any4;
  logic [1:0] idx4;
  logic [3:0] gnt4;

  // N=5 instance
  logic       rst5, iv5, mode5;
  logic [4:0] req5;
  logic       ov5, any5;
  logic [2:0] idx5;
  logic [4:0] gnt5;

  prio_encoder_rr #(.N(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .mode(mode8), .req(req8),
    .out_valid(ov8), .out_idx(idx8), .out_grant(gnt8), .out_any(any8)
  );

  prio_encoder_rr #(.N(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(iv4), .mode(mode4), .req(req4),
    .out_valid(ov4), .out_idx(idx4), .out_grant(gnt4), .out_any(any4)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk(clk), .rst(rst5), .in_valid(iv5), .mode(mode5), .req(req5),
    .out_valid(ov5), .out_idx(idx5), .out_grant(gnt5), .out_any(any5)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic       mode;
    logic [7:0] req;
    logic       ev;
    logic [2:0] eidx;
    logic [7:0] egnt;
    logic       eany;
  } vec_t;

  typedef struct {
    int         sel;
    string      tag;
    logic       ev;
    logic [7:0] eidx;
    logic [7:0] egnt;
    logic       eany;
  } exp_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];
  exp_t sb [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Wait for the edge, then pop the oldest expectation and compare it.
  task automatic settle_and_compare();
    exp_t e;
    logic       a_v, a_any;
    logic [7:0] a_idx, a_gnt;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sb.pop_front();
    case (e.sel)
      4: begin a_v = ov4; a_any = any4; a_idx = {6'b0, idx4}; a_gnt = {4'b0, gnt4}; end
      5: begin a_v = ov5; a_any = any5; a_idx = {5'b0, idx5}; a_gnt = {3'b0, gnt5}; end
      default: begin a_v = ov8; a_any = any8; a_idx = {5'b0, idx8}; a_gnt = gnt8; end
    endcase
    check({e.tag, "_valid"}, 64'(a_v),   64'(e.ev));
    check({e.tag, "_idx"},   64'(a_idx), 64'(e.eidx));
    check({e.tag, "_grant"}, 64'(a_gnt), 64'(e.egnt));
    check({e.tag, "_any"},   64'(a_any), 64'(e.eany));
  endtask

  task automatic drive8(input int n, input vec_t v);
    exp_t e;
    rst8 = v.rst; iv8 = v.iv; mode8 = v.mode; req8 = v.req;
    e.sel = 8; e.tag = $sformatf("n8_r%0d", n);
    e.ev = v.ev; e.eidx = {5'b0, v.eidx}; e.egnt = v.egnt; e.eany = v.eany;
    sb.push_back(e);
    settle_and_compare();
  endtask

  task automatic drive_small(input int sel, input string tag, input logic r, input logic iv,
                             input logic md, input logic [7:0] rq, input logic ev,
                             input logic [7:0] eidx, input logic [7:0] egnt, input logic eany);
    exp_t e;
    if (sel == 4) begin
      rst4 = r; iv4 = iv; mode4 = md; req4 = rq[3:0];
    end else begin
      rst5 = r; iv5 = iv; mode5 = md; req5 = rq[4:0];
    end
    e.sel = sel; e.tag = tag; e.ev = ev; e.eidx = eidx; e.egnt = egnt; e.eany = eany;
    sb.push_back(e);
    settle_and_compare();
  endtask

  initial begin
    // Table: rst, in_valid, mode, req -> valid, idx, grant, any
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b0}; // reset discards sample
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h52, 1'b1, 3'd6, 8'h40, 1'b1}; // fixed: highest bit 6
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 3'd0, 8'h01, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 3'd7, 8'h80, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 3'd7, 8'h80, 1'b1}; // idle: hold
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0}; // empty request
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b0}; // idle: hold
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0};
    for (int i = 0; i < 9; i++) begin                                 // rr sweep 0..7,0
      vecs[8 + i] = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 3'(i % 8), 8'(1 << (i % 8)), 1'b1};
    end
    vecs[17] = '{1'b0, 1'b1, 1'b0, 8'h06, 1'b1, 3'd2, 8'h04, 1'b1}; // fixed, ptr kept at 1
    vecs[18] = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 3'd1, 8'h02, 1'b1}; // rr resumes at 1
    vecs[19] = '{1'b0, 1'b1, 1'b1, 8'h40, 1'b1, 3'd6, 8'h40, 1'b1}; // ptr -> 7
    vecs[20] = '{1'b0, 1'b1, 1'b1, 8'h81, 1'b1, 3'd7, 8'h80, 1'b1}; // ptr -> 0
    vecs[21] = '{1'b0, 1'b1, 1'b1, 8'h81, 1'b1, 3'd0, 8'h01, 1'b1}; // ptr -> 1
    vecs[22] = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 3'd1, 8'h02, 1'b1}; // proves ptr was 1
    vecs[23] = '{1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 3'd4, 8'h10, 1'b1}; // ptr -> 5
    vecs[24] = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 3'd4, 8'h10, 1'b1}; // idle: hold, ptr 5
    vecs[25] = '{1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b0}; // reset beats sample
    vecs[26] = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 3'd0, 8'h00 | 8'h01, 1'b1}; // restart at 0
    vecs[27] = '{1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 3'd1, 8'h02, 1'b1};
    vecs[28] = '{1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 3'd0, 8'h01, 1'b1}; // wraps past 7 to 0

    rst8 = 1'b1; iv8 = 1'b0; mode8 = 1'b0; req8 = '0;
    rst4 = 1'b1; iv4 = 1'b0; mode4 = 1'b0; req4 = '0;
    rst5 = 1'b1; iv5 = 1'b0; mode5 = 1'b0; req5 = '0;
    @(posedge clk);
    #1;

    for (int n = 0; n < NVEC; n++) drive8(n, vecs[n]);
    rst8 = 1'b1; iv8 = 1'b0;

    // N=4, fixed priority
    drive_small(4, "n4_rst",  1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 8'h00, 1'b0);
    drive_small(4, "n4_0110", 1'b0, 1'b1, 1'b0, 8'h06, 1'b1, 8'd2, 8'h04, 1'b1);
    drive_small(4, "n4_1000", 1'b0, 1'b1, 1'b0, 8'h08, 1'b1, 8'd3, 8'h08, 1'b1);
    drive_small(4, "n4_zero", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'd0, 8'h00, 1'b0);
    rst4 = 1'b1; iv4 = 1'b0;

    // N=5, round-robin wrap at a non-power-of-two width
    drive_small(5, "n5_rst", 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'd0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive_small(5, $sformatf("n5_sweep%0d", i), 1'b0, 1'b1, 1'b1, 8'h1F,
                  1'b1, 8'(i % 5), 8'(1 << (i % 5)), 1'b1);
    end
    // ptr is 1 here: bit 4 wins, then the pointer must wrap to 0, not 5.
    drive_small(5, "n5_wrap_a", 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 8'd4, 8'h10, 1'b1);
    drive_small(5, "n5_wrap_b", 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 8'd0, 8'h01, 1'b1);
    rst5 = 1'b1; iv5 = 1'b0;

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_encoder_rr.md
PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

Interface
REQ-001 The block SHALL have parameter N, default 8: request width, legal range 2..64, power of two not required.
REQ-002 The block SHALL have derived parameter W, default $clog2(N): index width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: req is sampled this cycle.
REQ-006 The block SHALL have port mode, input, 1 bit: arbitration mode; 0 = fixed priority, 1 = round-robin.
REQ-007 The block SHALL have port req, input, N bits: request vector.
REQ-008 The block SHALL have port out_valid, output, 1 bit: registered result is valid.
REQ-009 The block SHALL have port out_idx, output, W bits: encoded index of the winning request.
REQ-010 The block SHALL have port out_grant, output, N bits: one-hot form of out_idx; all zero when no request.
REQ-011 The block SHALL have port out_any, output, 1 bit: the sampled req was nonzero.

Function
REQ-012 All outputs SHALL be registered, with latency 1 cycle: a sample with in_valid=1 at edge k appears at edge k+1.
REQ-013 With in_valid=1, out_valid SHALL be 1 on the next cycle; with in_valid=0, out_valid SHALL be 0 and out_idx/out_grant/out_any SHALL hold their previous values.
REQ-014 In mode 0, the winner SHALL be the highest set bit index of req.
REQ-015 In mode 1, the search SHALL begin at internal pointer ptr (W bits) and proceed ptr, ptr+1, ..., N-1, 0, ..., ptr-1; the first set bit wins.
REQ-016 After a mode-1 grant at index g, ptr SHALL be set to g+1, wrapping to 0 when g=N-1; this includes non-power-of-two N, where ptr never reaches N.
REQ-017 ptr SHALL update only when in_valid=1, mode=1 and req!=0; otherwise ptr SHALL hold.
REQ-018 In mode 0, ptr SHALL be retained unchanged, so that switching back to mode 1 resumes from the stored ptr.
REQ-019 For in_valid=1 with req=0, the outputs SHALL be out_valid=1, out_any=0, out_idx=0, out_grant=0, in either mode.
REQ-020 out_grant SHALL always equal 1<<out_idx when out_any=1; exactly one bit SHALL be set.
REQ-021 A mode change SHALL take effect on the same edge on which it is sampled alongside in_valid; there is no pipeline flush.
REQ-022 No combinational path SHALL exist from any input to any output.

Reset
REQ-023 With rst=1 at an edge, the block SHALL set out_valid=0, out_idx=0, out_grant=0, out_any=0 and ptr=0, regardless of in_valid, mode or req.
REQ-024 Reset SHALL take priority over a simultaneous valid sample; that sample SHALL be discarded.
REQ-025 Reset asserted mid-stream in mode 1 SHALL restart round-robin from index 0.

Verification
REQ-026 The bench SHALL check this scenario (N=8): mode=0, req=8'b0101_0010, in_valid=1 -> next cycle out_idx=6, out_grant=8'h40, out_any=1, out_valid=1.
REQ-027 The bench SHALL check this scenario (N=8): after reset, mode=1, req=8'hFF held for 9 valid cycles -> out_idx sequence 0,1,2,3,4,5,6,7,0.
REQ-028 The bench SHALL check this scenario (N=8): mode=1, ptr=7, req=8'h81 on two valid cycles -> out_idx=7, then 0; ptr ends at 1.
REQ-029 The bench SHALL check this scenario: in_valid=1, req=0 -> out_valid=1, out_any=0, out_idx=0, out_grant=0; then in_valid=0 -> out_valid=0, other outputs unchanged.
REQ-030 The bench SHALL check this scenario (N=8): mode=1 with ptr=5, rst=1 coincident with in_valid=1 and req=8'hFF -> all outputs 0; first valid req=8'hFF after reset -> out_idx=0.
REQ-031 The bench SHALL check this scenario (N=4, W=2): mode=0, req=4'b0110 -> out_idx=2'd2. In addition, N=5 in mode 1 with req=5'b11111 -> out_idx sequence 0..4,0, confirming the non-power-of-two wrap.
